// File: rtl/mips_axi_bridge_pkg.sv
// mips_axi_bridge_pkg
//   Shared definitions for the core-to-AXI bridge:
//   - default AXI IDs for the instruction and data ports
//   - AXI AxSIZE encodings
//   - read and write channel state encodings
package mips_axi_bridge_pkg;

  // Default AXI IDs; the top exposes them as parameters.
  localparam logic [3:0] ID_INST_DEF = 4'd0;
  localparam logic [3:0] ID_DATA_DEF = 4'd1;

  // AXI AxSIZE encodings for single-beat transfers.
  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  // Read channel: idle, address phase, data phase.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  // Write channel: idle, AW/W phase, response phase.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/mips_axi_bridge_axi_write_channel.sv
// axi_write_channel
//   Single-outstanding AXI write engine for data-port stores.
//   A store accepted by the top is captured here. AW and W are then
//   offered independently, and each valid is dropped once its own
//   handshake completes. After both are done the B response is
//   accepted, and done_o pulses for one cycle.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   store_hs_i             store accepted this cycle (capture request)
//   addr_i/size_i          store address and AXI size
//   wdata_i/wstrb_i        store data and byte strobes
//   aw*_o / awready_i      AXI write-address channel
//   w*_o / wready_i        AXI write-data channel
//   bvalid_i / bready_o    AXI write-response channel
//   idle_o                 engine can take a new store
//   done_o                 write response accepted this cycle
module axi_write_channel
  import mips_axi_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        store_hs_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic        idle_o,
  output logic        done_o
);

  wr_state_e   state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  assign awaddr_o = awaddr_q;
  assign awsize_o = awsize_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;
  assign idle_o   = (state_q == W_IDLE);

  // Write FSM next state, request capture and channel handshakes.
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (store_hs_i) begin
          awaddr_d  = addr_i;
          awsize_d  = size_i;
          wdata_d   = wdata_i;
          wstrb_d   = wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = W_REQ;
        end else begin
          state_d = W_IDLE;
        end
      end
      W_REQ: begin
        // AW and W complete in any order, possibly in the same cycle.
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        aw_done_d = aw_done_q | (awvalid_o & awready_i);
        w_done_d  = w_done_q | (wvalid_o & wready_i);
        if (aw_done_d && w_done_d) begin
          state_d = W_B;
        end else begin
          state_d = W_REQ;
        end
      end
      W_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          done_o  = 1'b1;
          state_d = W_IDLE;
        end else begin
          state_d = W_B;
        end
      end
      default: begin
        state_d = W_IDLE;
      end
    endcase
  end

  // Write FSM state and captured request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= W_IDLE;
      awaddr_q  <= 32'd0;
      awsize_q  <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/mips_axi_bridge.sv
// mips_axi_bridge
//   Converts the core's SRAM-like instruction and data ports into one
//   AXI4 master with single-beat transfers.
//   - One read is outstanding at a time, shared by fetches and loads.
//     Loads win ties against fetches.
//   - One data-port access (load or store) is outstanding at a time.
//     As a result, a load never overlaps a store to the same location.
//   - A store may proceed while a fetch read is outstanding.
// Ports:
//   clk, reset                         clock, async active-high reset
//   inst_*                             core fetch port
//   data_*                             core data port
//   ar*/r*                             AXI read channels
//   aw*/w*/b*                          AXI write channels (awid = ID_DATA,
//                                      len 0, INCR, wlast 1 tied outside)
module mips_axi_bridge
  import mips_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEF,
  parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;
  logic        data_busy_q, data_busy_d;

  logic rd_idle_s;
  logic wr_idle_s;
  logic wr_done_s;
  logic load_ok_s;
  logic store_ok_s;
  logic load_hs_s;
  logic store_hs_s;
  logic inst_hs_s;
  logic r_fire_s;

  assign rd_idle_s = (rd_state_q == R_IDLE);

  // Acceptance is suppressed during reset so nothing looks accepted while the
  // state is being forced.
  assign load_ok_s  = !reset && rd_idle_s && !data_busy_q;
  assign store_ok_s = !reset && wr_idle_s && !data_busy_q;

  // Data-port acceptance depends on the direction of the pending request.
  always_comb begin
    if (data_wr) begin
      data_addr_ok = store_ok_s;
    end else begin
      data_addr_ok = load_ok_s;
    end
  end

  assign load_hs_s  = data_req && !data_wr && data_addr_ok;
  assign store_hs_s = data_req && data_wr && data_addr_ok;

  // A fetch yields the read channel to a load accepted in the same cycle.
  assign inst_addr_ok = !reset && rd_idle_s && !load_hs_s;
  assign inst_hs_s    = inst_req && inst_addr_ok;

  assign arid   = arid_q;
  assign araddr = araddr_q;
  assign arsize = arsize_q;

  // Read FSM next state, AR capture and channel handshakes.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    arid_d     = arid_q;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (load_hs_s) begin
          araddr_d   = data_addr;
          arsize_d   = data_size;
          arid_d     = ID_DATA;
          rd_state_d = R_AR;
        end else if (inst_hs_s) begin
          araddr_d   = inst_addr;
          arsize_d   = AXI_SIZE_WORD;
          arid_d     = ID_INST;
          rd_state_d = R_AR;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          rd_state_d = R_R;
        end else begin
          rd_state_d = R_AR;
        end
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_state_d = R_R;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // Read responses are routed to the requesting port by RID.
  assign r_fire_s     = rvalid && rready;
  assign inst_data_ok = r_fire_s && (rid == ID_INST);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign data_data_ok = (r_fire_s && (rid == ID_DATA)) || wr_done_s;

  // The data-busy flag spans from data accept to its completion pulse.
  always_comb begin
    if (load_hs_s || store_hs_s) begin
      data_busy_d = 1'b1;
    end else if (data_data_ok) begin
      data_busy_d = 1'b0;
    end else begin
      data_busy_d = data_busy_q;
    end
  end

  // Read FSM state, AR registers and the data-busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q  <= R_IDLE;
      araddr_q    <= 32'd0;
      arsize_q    <= 3'd0;
      arid_q      <= 4'd0;
      data_busy_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      araddr_q    <= araddr_d;
      arsize_q    <= arsize_d;
      arid_q      <= arid_d;
      data_busy_q <= data_busy_d;
    end
  end

  axi_write_channel u_axi_write_channel (
    .clk_i      (clk),
    .rst_i      (reset),
    .store_hs_i (store_hs_s),
    .addr_i     (data_addr),
    .size_i     (data_size),
    .wdata_i    (data_wdata),
    .wstrb_i    (data_wstrb),
    .awaddr_o   (awaddr),
    .awsize_o   (awsize),
    .awvalid_o  (awvalid),
    .awready_i  (awready),
    .wdata_o    (wdata),
    .wstrb_o    (wstrb),
    .wvalid_o   (wvalid),
    .wready_i   (wready),
    .bvalid_i   (bvalid),
    .bready_o   (bready),
    .idle_o     (wr_idle_s),
    .done_o     (wr_done_s)
  );

endmodule

// File: tb/tb_mips_axi_bridge.sv
// tb_mips_axi_bridge
//   Directed scenarios with literal expectations, followed by a randomized
//   phase. In the randomized phase, the bench acts as both the core and
//   the AXI slave, and a transaction-level model predicts every output
//   on every cycle.
module tb_mips_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [2:0]  data_size;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  // Slave memory contents as a pure function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic idle_in();
    inst_req = 1'b0; inst_addr = 32'd0; data_req = 1'b0; data_wr = 1'b0;
    data_wstrb = 4'd0; data_addr = 32'd0; data_size = 3'd0; data_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Transaction-level model state and slave bookkeeping for the random phase.
  logic        m_rd_out, m_ar_sent, m_rd_data;
  logic [31:0] m_rd_addr;
  logic [2:0]  m_rd_size;
  logic        m_st_out, m_aw_sent, m_w_sent, m_busy;
  logic [31:0] m_st_addr, m_st_data;
  logic [2:0]  m_st_size;
  logic [3:0]  m_st_strb;
  logic        s_r_pend, s_b_pend, clr_inst, clr_data, r_clr, b_clr;
  logic [31:0] s_r_addr;
  logic [3:0]  s_r_id;
  int          n_inst = 0, n_load = 0, n_store = 0;

  // Predict every output from the outstanding transactions, then advance them.
  task automatic model_check();
    logic e_lok, e_dok, e_iok, dhs, ihs, e_arv, e_rr, e_awv, e_wv, e_br, rf, bf;
    e_lok = !m_rd_out && !m_busy;
    e_dok = data_wr ? !m_busy : e_lok;
    chk1("data_addr_ok", data_addr_ok, e_dok);
    dhs   = data_req && e_dok;
    e_iok = !m_rd_out && !(data_req && !data_wr && e_lok);
    chk1("inst_addr_ok", inst_addr_ok, e_iok);
    ihs   = inst_req && e_iok;
    e_arv = m_rd_out && !m_ar_sent;
    e_rr  = m_rd_out && m_ar_sent;
    chk1("arvalid", arvalid, e_arv);
    chk1("rready", rready, e_rr);
    if (e_arv) begin
      chk32("araddr", araddr, m_rd_addr);
      chk32("arsize", 32'(arsize), 32'(m_rd_size));
      chk32("arid", 32'(arid), 32'(m_rd_data));
    end
    e_awv = m_st_out && !m_aw_sent;
    e_wv  = m_st_out && !m_w_sent;
    e_br  = m_st_out && m_aw_sent && m_w_sent;
    chk1("awvalid", awvalid, e_awv);
    chk1("wvalid", wvalid, e_wv);
    chk1("bready", bready, e_br);
    if (e_awv) begin
      chk32("awaddr", awaddr, m_st_addr);
      chk32("awsize", 32'(awsize), 32'(m_st_size));
    end
    if (e_wv) begin
      chk32("wdata", wdata, m_st_data);
      chk32("wstrb", 32'(wstrb), 32'(m_st_strb));
    end
    rf = rvalid && e_rr;
    bf = bvalid && e_br;
    chk1("inst_data_ok", inst_data_ok, rf && !m_rd_data);
    chk1("data_data_ok", data_data_ok, (rf && m_rd_data) || bf);
    if (rf && !m_rd_data) begin
      chk32("inst_rdata", inst_rdata, mem_f(m_rd_addr));
      n_inst++;
    end
    if (rf && m_rd_data) begin
      chk32("data_rdata", data_rdata, mem_f(m_rd_addr));
      n_load++;
    end
    if (bf) n_store++;
    if (e_arv && arready) begin
      m_ar_sent = 1'b1; s_r_pend = 1'b1; s_r_addr = araddr; s_r_id = arid;
    end
    if (rf) begin
      m_rd_out = 1'b0; s_r_pend = 1'b0; r_clr = 1'b1;
      if (m_rd_data) m_busy = 1'b0;
    end
    if (e_awv && awready) m_aw_sent = 1'b1;
    if (e_wv && wready) m_w_sent = 1'b1;
    if (bf) begin
      m_st_out = 1'b0; m_busy = 1'b0; b_clr = 1'b1;
    end
    if (dhs) begin
      clr_data = 1'b1; m_busy = 1'b1;
      if (data_wr) begin
        m_st_out = 1'b1; m_aw_sent = 1'b0; m_w_sent = 1'b0;
        m_st_addr = data_addr; m_st_size = data_size;
        m_st_data = data_wdata; m_st_strb = data_wstrb;
      end else begin
        m_rd_out = 1'b1; m_ar_sent = 1'b0; m_rd_data = 1'b1;
        m_rd_addr = data_addr; m_rd_size = data_size;
      end
    end
    if (ihs) begin
      clr_inst = 1'b1; m_rd_out = 1'b1; m_ar_sent = 1'b0; m_rd_data = 1'b0;
      m_rd_addr = inst_addr; m_rd_size = 3'd2;
    end
    s_b_pend = m_st_out && m_aw_sent && m_w_sent;
  endtask

  initial begin
    int ni, nd, ci, cd;
    idle_in();
    reset = 1'b1;
    inst_req = 1'b1;
    data_req = 1'b1;
    // Reset state: even with requests pending, nothing is accepted or valid.
    at_neg();
    chk32("reset_ctl", 32'({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok,
                            data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    chk32("reset_araddr", araddr, 32'd0);
    chk32("reset_awaddr", awaddr, 32'd0);
    step(); idle_in(); reset = 1'b0;

    // Fetch with arready at cycle 1 and rvalid at cycle 3.
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; arready = 1'b1;
    at_neg(); chk1("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0;
    at_neg(); chk1("t1_arvalid", arvalid, 1'b1);
    chk32("t1_araddr", araddr, 32'hBFC0_0000);
    chk32("t1_arsize", 32'(arsize), 32'd2);
    chk32("t1_arid", 32'(arid), 32'd0);
    step();
    at_neg(); chk1("t1_rready", rready, 1'b1); chk1("t1_no_early_ok", inst_data_ok, 1'b0);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C08_0001;
    at_neg(); chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk32("t1_inst_rdata", inst_rdata, 32'h3C08_0001);
    chk1("t1_no_data_ok", data_data_ok, 1'b0);
    step(); rvalid = 1'b0;
    at_neg(); chk1("t1_rready_drop", rready, 1'b0);

    // Fetch and byte load in the same cycle: the load wins.
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; data_size = 3'd0;
    at_neg(); chk1("t2_data_addr_ok", data_addr_ok, 1'b1);
    chk1("t2_inst_blocked", inst_addr_ok, 1'b0);
    step(); data_req = 1'b0;
    at_neg(); chk32("t2_arid", 32'(arid), 32'd1);
    chk32("t2_arsize", 32'(arsize), 32'd0);
    chk32("t2_araddr", araddr, 32'h8000_1000);
    chk1("t2_inst_wait", inst_addr_ok, 1'b0);
    step(); rvalid = 1'b1; rid = 4'd1; rdata = 32'h1122_3344;
    at_neg(); chk1("t2_data_data_ok", data_data_ok, 1'b1);
    chk32("t2_data_rdata", data_rdata, 32'h1122_3344);
    chk1("t2_no_inst_ok", inst_data_ok, 1'b0);
    step(); rvalid = 1'b0;
    at_neg(); chk1("t2_inst_accept", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0;
    at_neg(); chk32("t2_fetch_arid", 32'(arid), 32'd0);
    chk32("t2_fetch_araddr", araddr, 32'hBFC0_0004);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h2402_0005;
    at_neg(); chk32("t2_inst_rdata", inst_rdata, 32'h2402_0005);
    chk1("t2_inst_data_ok", inst_data_ok, 1'b1);
    step(); rvalid = 1'b0;

    // Store with W two cycles before AW; a load to the same address waits.
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_2000; data_size = 3'd2;
    data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF; awready = 1'b0; wready = 1'b1;
    at_neg(); chk1("t3_store_accept", data_addr_ok, 1'b1);
    step(); data_wr = 1'b0;
    at_neg(); chk1("t3_awvalid", awvalid, 1'b1); chk1("t3_wvalid", wvalid, 1'b1);
    chk32("t3_awaddr", awaddr, 32'h8000_2000);
    chk32("t3_wdata", wdata, 32'hDEAD_BEEF);
    chk32("t3_wstrb", 32'(wstrb), 32'd3);
    chk1("t3_load_blocked", data_addr_ok, 1'b0);
    step(); wready = 1'b0;
    at_neg(); chk1("t3_wvalid_drop", wvalid, 1'b0); chk1("t3_aw_hold", awvalid, 1'b1);
    step(); awready = 1'b1;
    at_neg(); chk1("t3_aw_still", awvalid, 1'b1); chk1("t3_no_bready", bready, 1'b0);
    step(); awready = 1'b0;
    at_neg(); chk1("t3_aw_drop", awvalid, 1'b0); chk1("t3_bready", bready, 1'b1);
    chk1("t3_no_ok", data_data_ok, 1'b0); chk1("t3_load_blocked2", data_addr_ok, 1'b0);
    step(); bvalid = 1'b1;
    at_neg(); chk1("t3_store_ok", data_data_ok, 1'b1); chk1("t3_load_blocked3", data_addr_ok, 1'b0);
    step(); bvalid = 1'b0;
    at_neg(); chk1("t3_bready_drop", bready, 1'b0); chk1("t3_load_accept", data_addr_ok, 1'b1);
    step(); data_req = 1'b0;
    at_neg(); chk32("t3_load_araddr", araddr, 32'h8000_2000); chk32("t3_load_arid", 32'(arid), 32'd1);
    step(); rvalid = 1'b1; rid = 4'd1; rdata = 32'hCAFE_F00D;
    at_neg(); chk1("t3_load_ok", data_data_ok, 1'b1); chk32("t3_load_rdata", data_rdata, 32'hCAFE_F00D);
    step(); rvalid = 1'b0;

    // Store completes while a fetch waits for delayed read data.
    ni = 0; nd = 0; ci = -1; cd = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      inst_req = (c == 0); inst_addr = 32'hBFC0_0008;
      data_req = (c == 1); data_wr = 1'b1; data_addr = 32'h8000_3000;
      data_wstrb = 4'hF; data_wdata = 32'h1234_5678; awready = 1'b1; wready = 1'b1;
      bvalid = (c == 3); rvalid = (c == 7); rid = 4'd0; rdata = 32'h8C02_0000;
      at_neg();
      if (c == 1) chk1("t4_store_accept", data_addr_ok, 1'b1);
      if (inst_data_ok) begin ni++; ci = c; end
      if (data_data_ok) begin nd++; cd = c; end
    end
    chk32("t4_inst_pulses", ni, 32'd1);
    chk32("t4_data_pulses", nd, 32'd1);
    chk1("t4_b_before_r", (cd >= 0) && (cd < ci), 1'b1);

    // Asynchronous reset with a read in R_R and a store in W_REQ.
    step(); idle_in(); inst_req = 1'b1; inst_addr = 32'hBFC0_000C; arready = 1'b1;
    step(); inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_4000;
    step(); data_req = 1'b0;
    at_neg(); chk1("t5_pre_rready", rready, 1'b1); chk1("t5_pre_awvalid", awvalid, 1'b1);
    #2; reset = 1'b1; rvalid = 1'b1; rid = 4'd0; bvalid = 1'b1;
    #1;
    chk32("t5_reset_ctl", 32'({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok,
                               data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    step(); step(); reset = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    at_neg(); chk1("t5_post_accept", inst_addr_ok, 1'b1); chk1("t5_store_gone", awvalid, 1'b0);
    step(); inst_req = 1'b0;
    at_neg(); chk32("t5_post_araddr", araddr, 32'hBFC0_0010);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C1D_8000;
    at_neg(); chk1("t5_post_ok", inst_data_ok, 1'b1); chk32("t5_post_rdata", inst_rdata, 32'h3C1D_8000);
    step(); rvalid = 1'b0;

    // Randomized traffic against the transaction-level model.
    idle_in();
    m_rd_out = 1'b0; m_ar_sent = 1'b0; m_rd_data = 1'b0; m_rd_addr = 32'd0; m_rd_size = 3'd0;
    m_st_out = 1'b0; m_aw_sent = 1'b0; m_w_sent = 1'b0; m_busy = 1'b0;
    m_st_addr = 32'd0; m_st_data = 32'd0; m_st_size = 3'd0; m_st_strb = 4'd0;
    s_r_pend = 1'b0; s_b_pend = 1'b0; s_r_addr = 32'd0; s_r_id = 4'd0;
    clr_inst = 1'b0; clr_data = 1'b0; r_clr = 1'b0; b_clr = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      if (clr_inst) begin inst_req = 1'b0; clr_inst = 1'b0; end
      if (clr_data) begin data_req = 1'b0; clr_data = 1'b0; end
      if (!inst_req && ($urandom_range(0, 2) == 0)) begin
        inst_req = 1'b1; inst_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!data_req && ($urandom_range(0, 2) == 0)) begin
        data_req = 1'b1; data_wr = 1'($urandom_range(0, 1));
        data_addr = $urandom(); data_size = 3'($urandom_range(0, 2));
        data_wstrb = 4'($urandom()); data_wdata = $urandom();
      end
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      if (r_clr) begin rvalid = 1'b0; r_clr = 1'b0; end
      if (s_r_pend && !rvalid && ($urandom_range(0, 1) == 1)) begin
        rvalid = 1'b1; rid = s_r_id; rdata = mem_f(s_r_addr);
      end
      if (b_clr) begin bvalid = 1'b0; b_clr = 1'b0; end
      if (s_b_pend && !bvalid && ($urandom_range(0, 1) == 1)) bvalid = 1'b1;
      at_neg();
      model_check();
    end
    chk1("rand_inst_traffic", n_inst > 20, 1'b1);
    chk1("rand_load_traffic", n_load > 20, 1'b1);
    chk1("rand_store_traffic", n_store > 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
